// File: rtl/serial_stim_capture_if.sv
// Handshake and serial-target signals of the stimulus/capture engine.
// The master side is the host plus the serial target (it drives z).
// The slave side is the engine.
interface serial_stim_capture_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] pattern;
  logic             x;
  logic             x_en;
  logic             z;
  logic             busy;
  logic             resp_valid;
  logic [WIDTH-1:0] resp;
  logic             resp_ready;

  modport master (
    output start_valid, pattern, resp_ready, z,
    input  start_ready, x, x_en, busy, resp_valid, resp
  );

  modport slave (
    input  start_valid, pattern, resp_ready, z,
    output start_ready, x, x_en, busy, resp_valid, resp
  );
endinterface

// File: rtl/serial_stim_capture.sv
// Serial stimulus-and-capture engine.
// Shifts a WIDTH-bit pattern out MSB-first on x, one bit per clock.
// Captures the target's z response, delayed by two cycles, into resp.
// Returns resp over a valid/ready handshake.
module serial_stim_capture #(
  parameter int unsigned WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  serial_stim_capture_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] CNT_W     = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST  = CW'(WIDTH + 1);
  localparam logic [CW-1:0] CNT_CAP0  = CW'(2);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] resp_q, resp_d;
  logic             x_q, x_d;
  logic             xen_q, xen_d;

  // State and datapath registers.  Reset aborts any run, which also drops x.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      resp_q  <= '0;
      x_q     <= 1'b0;
      xen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      resp_q  <= resp_d;
      x_q     <= x_d;
      xen_q   <= xen_d;
    end
  end

  // Next-state logic.  The drive and capture windows are both keyed off cnt.
  // Capture lags drive by two edges: one edge for the target to sample x,
  // and one edge for z to be captured.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    resp_d  = resp_q;
    x_d     = 1'b0;
    xen_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start_valid) begin
          sh_d    = bus.pattern;
          cnt_d   = '0;
          resp_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (cnt_q < CNT_W) begin
          x_d   = sh_q[WIDTH-1];
          xen_d = 1'b1;
          sh_d  = {sh_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q >= CNT_CAP0) begin
          resp_d = {resp_q[WIDTH-2:0], bus.z};
        end
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.start_ready = (state_q == IDLE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.resp_valid  = (state_q == DONE);
  assign bus.resp        = resp_q;
  assign bus.x           = x_q;
  assign bus.x_en        = xen_q;
endmodule

// File: tb/tb_serial_stim_capture.sv
// Scoreboard bench for serial_stim_capture.
// Two targets can be selected: a loopback flop fed by x, and a
// toggle flop with z = ~c.
module tb_serial_stim_capture;
  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  serial_stim_capture_if #(.WIDTH(W)) bus ();
  serial_stim_capture #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic tgt_mode;
  logic zq, c;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      zq <= 1'b0;
      c  <= 1'b0;
    end else begin
      zq <= bus.x;
      c  <= ~c;
    end
  end
  assign bus.z = tgt_mode ? ~c : zq;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_acc    = 0;
  int n_resp   = 0;
  logic [W-1:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: count acceptances, and pop/compare each completed response.
  always @(negedge clk) begin : monitor
    logic [W-1:0] e;
    if (rst && bus.start_ready && bus.start_valid) n_acc++;
    if (rst && bus.resp_valid && bus.resp_ready) begin
      n_resp++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: got 0x%0h with empty scoreboard", bus.resp);
      end else begin
        e = exp_q.pop_front();
        check("resp_word", bus.resp, e);
      end
    end
  end

  task automatic accept(input logic [W-1:0] pat, input logic [W-1:0] exp, output int t);
    bus.pattern     = pat;
    bus.start_valid = 1'b1;
    for (int i = 0; i < 100 && !bus.start_ready; i++) @(posedge clk) #1;
    if (!bus.start_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: start_ready=%0b required 1", bus.start_ready);
    end
    @(posedge clk) #1;
    t = cyc;
    exp_q.push_back(exp);
    bus.start_valid = 1'b0;
  endtask

  task automatic observe(input logic [W-1:0] pat, input bit poke, output int t_valid);
    logic [W-1:0] xw;
    int nen;
    bit sr_low, xbad;
    xw = '0; nen = 0; sr_low = 1'b1; xbad = 1'b0; t_valid = -1;
    for (int j = 1; j <= int'(W) + 2; j++) begin
      @(posedge clk) #1;
      if (poke && j == 3) begin bus.start_valid = 1'b1; bus.pattern = 8'hAA; end
      if (poke && j == 6) bus.start_valid = 1'b0;
      if (bus.x_en) begin xw = {xw[W-2:0], bus.x}; nen++; end
      else if (bus.x !== 1'b0) xbad = 1'b1;
      if (bus.start_ready) sr_low = 1'b0;
      if (bus.resp_valid && t_valid < 0) t_valid = j;
    end
    check("x_bits", xw, pat);
    check("x_en_cycles", nen, W);
    check("start_ready_low_in_run", sr_low, 1);
    check("x_zero_outside_en", xbad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, tv, acc0, nr;
    bit bad;
    tgt_mode = 1'b0;
    bus.start_valid = 1'b0;
    bus.pattern = '0;
    bus.resp_ready = 1'b0;
    #1;
    check("rst_start_ready", bus.start_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_x", bus.x, 0);
    check("rst_x_en", bus.x_en, 0);
    check("rst_resp", bus.resp, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk) #1;

    // Loopback 0xB4 with latency check
    bus.resp_ready = 1'b1;
    accept(8'hB4, 8'hB4, t0);
    observe(8'hB4, 1'b0, tv);
    check("resp_valid_latency", tv, W + 2);
    @(posedge clk) #1;
    check("post_hs_start_ready", bus.start_ready, 1);
    check("post_hs_busy", bus.busy, 0);
    check("post_hs_resp_valid", bus.resp_valid, 0);

    // Back-to-back 0xFF then 0x01
    accept(8'hFF, 8'hFF, t0);
    observe(8'hFF, 1'b0, tv);
    accept(8'h01, 8'h01, t1);
    check("b2b_spacing", t1 - t0, W + 4);
    observe(8'h01, 1'b0, tv);
    @(posedge clk) #1;

    // Stalled consumer 0x3C
    bus.resp_ready = 1'b0;
    accept(8'h3C, 8'h3C, t0);
    observe(8'h3C, 1'b0, tv);
    acc0 = n_acc; nr = n_resp; bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk) #1;
      bus.start_valid = i[0];
      bus.pattern = 8'h99;
      if (!bus.resp_valid || bus.resp !== 8'h3C || !bus.busy) bad = 1'b1;
    end
    bus.start_valid = 1'b0;
    check("stall_hold", bad, 0);
    check("stall_no_second_run", n_acc, acc0);
    check("stall_no_pop", n_resp, nr);
    bus.resp_ready = 1'b1;
    @(posedge clk) #1;
    check("stall_release_valid", bus.resp_valid, 0);
    check("stall_release_ready", bus.start_ready, 1);
    check("resp_held_in_idle", bus.resp, 8'h3C);

    // Ignored start mid-run
    accept(8'h5A, 8'h5A, t0);
    acc0 = n_acc;
    observe(8'h5A, 1'b1, tv);
    check("ignored_start_runs", n_acc, acc0);
    @(posedge clk) #1;

    // Reset mid-run
    accept(8'hC3, 8'h00, t0);
    repeat (4) @(posedge clk) #1;
    nr = n_resp;
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("abort_x", bus.x, 0);
    check("abort_x_en", bus.x_en, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_resp", bus.resp, 0);
    check("abort_start_ready", bus.start_ready, 1);
    check("abort_resp_valid", bus.resp_valid, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    check("abort_no_resp", n_resp, nr);
    accept(8'h81, 8'h81, t0);
    observe(8'h81, 1'b0, tv);
    @(posedge clk) #1;

    // Toggle target cleared by shared reset; accept on first edge after release
    rst = 1'b0;
    tgt_mode = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    accept(8'h00, 8'h55, t0);
    observe(8'h00, 1'b0, tv);
    @(posedge clk) #1;

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk) #1;
    check("scoreboard_drained", exp_q.size(), 0);
    check("resp_count", n_resp, 7);
    check("accept_count", n_acc, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_stim_capture.md
# serial_stim_capture

Serial stimulus-and-capture engine that drives the single-bit `x` input of a bit-serial sequential target and collects the target's single-bit `z` response. It accepts a WIDTH-bit pattern over a valid/ready handshake and shifts it out MSB-first, one bit per clock. It then captures WIDTH response bits, aligned one cycle after each bit is sampled, and returns them as a word over a second valid/ready handshake. It sits between bench or host control logic and any `x`/`z` serial target in the basics library.

## Interface
Parameters:
- WIDTH, 8, bits per pattern and per response word; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock shared with the target
- rst  input  1  asynchronous, active-low reset; shared with the target
- start_valid  input  1  pattern offered
- start_ready  output  1  engine idle, can accept a pattern
- pattern  input  WIDTH  stimulus word; bit WIDTH-1 is sent first
- x  output  1  registered serial stimulus to target
- x_en  output  1  registered; high on cycles where `x` carries a pattern bit
- z  input  1  serial response from target; combinational from target state
- busy  output  1  high whenever not IDLE
- resp_valid  output  1  response word available
- resp  output  WIDTH  captured response; first captured bit in bit WIDTH-1
- resp_ready  input  1  consumer accepts response

## Operation
- FSM states:
  - IDLE: start_ready=1. On start_valid at an edge, load the shift register from `pattern`, set cnt=0, and go to RUN.
  - RUN: drive bits and capture responses. Go to DONE at the edge where cnt reaches WIDTH+1.
  - DONE: resp_valid=1. On resp_ready at an edge, go to IDLE.
- A start handshake is accepted only in IDLE. start_valid in RUN or DONE is ignored, not queued, and `pattern` is not sampled.
- `pattern` is sampled only at the acceptance edge; later changes have no effect.
- Drive path:
  - `x` is registered and is 0 whenever no bit is being driven.
  - Bits go out MSB-first. After the edge with cnt=k (k=0..WIDTH-1), x = pattern[WIDTH-1-k] and x_en=1.
  - After cnt reaches WIDTH, x=0 and x_en=0.
- Capture path:
  - At edges where cnt=2..WIDTH+1, `z` is shifted into `resp` from bit 0. The first captured bit ends in resp[WIDTH-1].
  - `resp` is not modified outside those edges.
- `resp` holds stable from DONE entry until the next acceptance. It is cleared to 0 at acceptance.
- The counter is sized clog2(WIDTH+2) bits. It never wraps; it saturates on DONE entry.
- Reset (async, rst=0): state=IDLE, cnt=0, x=0, x_en=0, resp=0, resp_valid=0, busy=0, start_ready=1.
- Reset asserted mid-RUN or mid-DONE aborts immediately. The partial response is discarded, no resp_valid is produced, and `x` drops to 0 asynchronously.

## Timing
- Let E0 be the acceptance edge. Pattern bit k is on `x` between edges E_k+1 and E_k+2 (the cycle after E_k+1), so the target samples bit k at edge E_k+2.
- Target `z` reflecting bit k is valid after edge E_k+2 and is captured at edge E_k+3.
- resp_valid rises after edge E_(WIDTH+2), which is WIDTH+2 cycles after acceptance.
- x_en is high for exactly WIDTH consecutive cycles, starting the cycle after E1.
- The response handshake completes at the first edge with resp_valid=1 and resp_ready=1. resp_valid and busy fall, and start_ready rises, the cycle after that edge. If resp_ready is held high, the minimum spacing between acceptances is WIDTH+4 cycles.
- resp_ready while not in DONE is ignored.
- No combinational path from start_valid or resp_ready to any output except through state.

## Test plan
- Loopback, where the bench drives z from a flop fed by `x`: pattern=0xB4, WIDTH=8 -> `x` shows 1,0,1,1,0,1,0,0 under x_en; resp=0xB4; resp_valid rises 10 cycles after acceptance.
- Loopback, back-to-back: patterns 0xFF then 0x01, with resp_ready tied high -> responses 0xFF then 0x01; second acceptance exactly 12 cycles after the first; start_ready low throughout each run.
- Stalled consumer: pattern=0x3C, resp_ready held low for 20 cycles -> resp stays 0x3C with resp_valid=1; start_valid pulses are ignored and no second run starts; completes on the first resp_ready.
- Ignored start: toggle start_valid and change `pattern` to 0xAA mid-run of 0x5A -> response is 0x5A; only one run occurs.
- Reset mid-run: assert rst low 4 cycles after accepting 0xC3 -> x=0, x_en=0, busy=0, resp=0, start_ready=1 immediately; no resp_valid; a new 0x81 run after release returns 0x81.
- Reset-check target: toggle-output target cleared by the shared reset, where each clock toggles a flop c and z=~c; pattern=0x00 -> resp=0x55.
